// File: rtl/varlen_packer.sv
// Variable-length bit packer: each value is trimmed to its MSB and appended LSB-first into a frame.
// Optional macro VLP_ZERO_CODE_EN encodes a zero value as a single 0 bit instead of skipping it.
module varlen_packer #(
    parameter int WIDTH = 16,
    parameter int COUNT = 2,
    parameter int OUT_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       done,
    output logic [OUT_W-1:0]           out_data,
    output logic [OUT_W-1:0]           out_s,
    output logic [$clog2(OUT_W+1)-1:0] out_len,
    output logic                       out_ovf,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int PW = $clog2(OUT_W + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, EMIT} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_val;
    logic [IW-1:0]    r_p, r_idx;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [OUT_W-1:0] r_data, r_s;
    logic             r_ovf, r_done;

    logic [IW-1:0]    w_p;
    logic [PW-1:0]    w_pos;
    logic [OUT_W-1:0] w_bit, w_end;
    logic             w_accept, w_field, w_fits, w_add, w_last, w_full, w_done_set;

    function automatic logic [IW-1:0] f_msb(input logic [WIDTH-1:0] v);
        f_msb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) f_msb = IW'(i);
        end
    endfunction

    assign w_accept = in_valid && in_ready;
    assign w_p      = f_msb(r_val);
    assign w_fits   = (32'(r_ptr) + 32'(w_p) + 32'd1) <= 32'(OUT_W);
`ifdef VLP_ZERO_CODE_EN
    assign w_field  = 1'b1;
`else
    assign w_field  = |r_val;
`endif
    assign w_add    = w_field && w_fits;
    assign w_last   = (r_idx == r_p);
    assign w_full   = (r_cnt == CW'(COUNT));
    // r_val shifts right during WRITE, so bit 0 is always the next bit to place
    assign w_pos    = r_ptr + PW'(r_idx);
    assign w_bit    = {{(OUT_W-1){1'b0}}, r_val[0]} << w_pos;
    assign w_end    = {{(OUT_W-1){1'b0}}, 1'b1} << w_pos;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept)                      w_next = LOAD;
                else if (flush && (r_cnt != '0))   w_next = EMIT;
            end
            LOAD: begin
                if (w_add)       w_next = WRITE;
                else if (w_full) w_next = EMIT;
                else begin
                    w_next     = IDLE;
                    w_done_set = 1'b1;
                end
            end
            WRITE: begin
                if (w_last) begin
                    w_next     = w_full ? EMIT : IDLE;
                    w_done_set = !w_full;
                end
            end
            EMIT: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_val  <= '0;
            r_p    <= '0;
            r_idx  <= '0;
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_s    <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_val <= in_b;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                LOAD: begin
                    r_p   <= w_p;
                    r_idx <= '0;
                    if (w_field && !w_fits) r_ovf <= 1'b1;
                end
                WRITE: begin
                    r_data <= r_data | w_bit;
                    r_val  <= r_val >> 1;
                    r_idx  <= r_idx + IW'(1);
                    if (w_last) begin
                        r_s   <= r_s | w_end;
                        r_ptr <= r_ptr + PW'(r_p) + PW'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_data <= '0;
                        r_s    <= '0;
                        r_ptr  <= '0;
                        r_cnt  <= '0;
                        r_ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !flush;
    assign out_valid = (r_state == EMIT);
    assign out_data  = r_data;
    assign out_s     = r_s;
    assign out_len   = r_ptr;
    assign out_ovf   = r_ovf;
    assign done      = r_done;

endmodule

// File: tb/tb_varlen_packer.sv
// Directed bench for varlen_packer: a default instance plus an OUT_W=16 instance for frame overflow.
module tb_varlen_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_b = '0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        in_ready, done, out_ovf, out_valid;
    logic [63:0] out_data, out_s;
    logic [6:0]  out_len;

    logic [15:0] b_in = '0;
    logic        b_valid = 1'b0, b_flush = 1'b0, b_oready = 1'b0;
    logic        b_ready, b_done, b_ovf, b_ovalid;
    logic [15:0] b_data, b_s;
    logic [4:0]  b_len;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int n;

    varlen_packer dut (
        .clk(clk), .rst(rst), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .done(done), .out_data(out_data), .out_s(out_s), .out_len(out_len),
        .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    varlen_packer #(.WIDTH(16), .COUNT(2), .OUT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_b(b_in), .in_valid(b_valid), .in_ready(b_ready),
        .flush(b_flush), .done(b_done), .out_data(b_data), .out_s(b_s), .out_len(b_len),
        .out_ovf(b_ovf), .out_valid(b_ovalid), .out_ready(b_oready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] v);
        int k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        in_b     = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("out_valid_rise", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_fall", {63'd0, out_valid}, 64'd0);
        chk("len_cleared", 64'(out_len), 64'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_data", out_data, 64'd0);
        chk("rst_s", out_s, 64'd0);
        chk("rst_len", 64'(out_len), 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        // 0x0005 then 0x0013, with busy time and done timing
        done_cnt = 0;
        send(16'h0005);
        n = 0;
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles_5", 64'(n), 64'd4);
        chk("done_after_first", {63'd0, done}, 64'd1);
        send(16'h0013);
        wait_valid();
        chk("f1_data", out_data, 64'h9D);
        chk("f1_s", out_s, 64'h84);
        chk("f1_len", 64'(out_len), 64'd8);
        chk("f1_ovf", {63'd0, out_ovf}, 64'd0);
        chk("f1_done_cnt", 64'(done_cnt), 64'd1);
        take();

        // zero value handling
        send(16'h0000);
        send(16'h0001);
        wait_valid();
`ifdef VLP_ZERO_CODE_EN
        chk("z_data", out_data, 64'h2);
        chk("z_s", out_s, 64'h3);
        chk("z_len", 64'(out_len), 64'd2);
`else
        chk("z_data", out_data, 64'h1);
        chk("z_s", out_s, 64'h1);
        chk("z_len", 64'(out_len), 64'd1);
`endif
        take();

        // flush with an empty frame is ignored
        flush = 1'b1;
        #1;
        chk("flush_blocks_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("empty_flush_valid", {63'd0, out_valid}, 64'd0);
        chk("empty_flush_ready", {63'd0, in_ready}, 64'd1);

        // partial frame closed by flush, held under backpressure
        send(16'h0006);
        n = 0;
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", out_data, 64'h6);
            chk("hold_s", out_s, 64'h4);
            chk("hold_len", 64'(out_len), 64'd3);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        take();

        // reset in the middle of WRITE
        send(16'hFFFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_s", out_s, 64'd0);
        chk("mid_rst_len", 64'(out_len), 64'd0);
        chk("mid_rst_ovf", {63'd0, out_ovf}, 64'd0);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(16'h0001);
        send(16'h0001);
        wait_valid();
        chk("post_rst_data", out_data, 64'h3);
        chk("post_rst_s", out_s, 64'h3);
        chk("post_rst_len", 64'(out_len), 64'd2);
        take();

        // OUT_W=16: second value does not fit and is dropped
        b_in    = 16'hFFFF;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        n = 0;
        while (!b_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b_busy_cycles", 64'(n), 64'd17);
        b_in    = 16'h0003;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        n = 0;
        while (!b_ovalid && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b_valid", {63'd0, b_ovalid}, 64'd1);
        chk("b_data", 64'(b_data), 64'hFFFF);
        chk("b_s", 64'(b_s), 64'h8000);
        chk("b_len", 64'(b_len), 64'd16);
        chk("b_ovf", {63'd0, b_ovf}, 64'd1);
        b_oready = 1'b1;
        @(negedge clk);
        b_oready = 1'b0;
        chk("b_valid_fall", {63'd0, b_ovalid}, 64'd0);
        chk("b_ovf_cleared", {63'd0, b_ovf}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
